// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the program counter and its return stack.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int PC_WIDTH = 4;
    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam int unsigned PC_RESET = 0;

    // One command per cycle, chosen after priority encoding of the control word.
    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_JUMP,
        PC_CALL,
        PC_RET
    } pc_cmd_e;

    // The stack pointer must count 0..depth inclusive, so it needs one extra state.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Hardware call/return stack: DEPTH x WIDTH register array with a push/pop pointer.
// Latency: push/pop take effect on the next rising edge; rdata (top of stack) is registered-state combinational.
// Backpressure: none; a push when full or a pop when empty is dropped and reported on fault.
// Ports: clk, clr (async active-high); push/pop/wdata in; rdata, full, empty, fault out.
module pc_return_stack
    import cpu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             fault
);

    localparam int SPW  = sp_width(DEPTH);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [IDXW-1:0]  wr_idx;
    logic [IDXW-1:0]  rd_idx;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);

    // Gating: a push into a full stack or a pop from an empty one never touches state.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign fault   = (push & full) | (pop & empty);

    // Indices are only meaningful when the matching operation is legal, so truncation is safe.
    assign wr_idx = IDXW'(sp_q);
    assign rd_idx = IDXW'(sp_q - SPW'(1));
    assign rdata  = empty ? '0 : mem_q[rd_idx];

    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (pop_ok) begin
            sp_d = sp_q - SPW'(1);
        end else if (push_ok) begin
            mem_d[wr_idx] = wdata;
            sp_d          = sp_q + SPW'(1);
        end
    end

    // The array shares the async clear so an edge seen while clr is high cannot land a push.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sp_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with increment, jump and a DEPTH-entry hardware call/return stack.
// Latency: one command per cycle, result visible on out the cycle after the rising edge.
// Backpressure: none; overflow/underflow drop the command and set the sticky stack_err.
// Ports: clk, clr (async active-high); ce, j, call, ret, bus in; out, stack_empty,
// stack_full, stack_err out. Optional PC_COND_JUMP_EN adds jz, jc, zf, cf inputs.
module program_counter_stack
    import cpu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    input  logic             j,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] bus,
`ifdef PC_COND_JUMP_EN
    input  logic             jz,
    input  logic             jc,
    input  logic             zf,
    input  logic             cf,
`endif
    output logic [WIDTH-1:0] out,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    pc_cmd_e          cmd;
    logic [WIDTH-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] stk_rdata;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_fault;

    // Priority: ret > call > j [> jz > jc] > ce. A failed conditional jump holds
    // the PC rather than falling through to ce.
    always_comb begin
        cmd = PC_HOLD;
        if (ret) begin
            cmd = PC_RET;
        end else if (call) begin
            cmd = PC_CALL;
        end else if (j) begin
            cmd = PC_JUMP;
`ifdef PC_COND_JUMP_EN
        end else if (jz) begin
            cmd = zf ? PC_JUMP : PC_HOLD;
        end else if (jc) begin
            cmd = cf ? PC_JUMP : PC_HOLD;
`endif
        end else if (ce) begin
            cmd = PC_INC;
        end
    end

    // Wraps silently at all-ones; also the return address pushed by a call.
    assign pc_inc = out_q + WIDTH'(1);

    pc_return_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_stack (
        .clk  (clk),
        .clr  (clr),
        .push (cmd == PC_CALL),
        .pop  (cmd == PC_RET),
        .wdata(pc_inc),
        .rdata(stk_rdata),
        .full (stk_full),
        .empty(stk_empty),
        .fault(stk_fault)
    );

    always_comb begin
        out_d = out_q;
        err_d = err_q | stk_fault;
        case (cmd)
            PC_INC:  out_d = pc_inc;
            PC_JUMP: out_d = bus;
            PC_CALL: if (!stk_full)  out_d = bus;
            PC_RET:  if (!stk_empty) out_d = stk_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_q <= WIDTH'(PC_RESET);
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign out         = out_q;
    assign stack_empty = stk_empty;
    assign stack_full  = stk_full;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_program_counter_stack.sv
module tb_program_counter_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr = 1'b1;
    logic       ce = 1'b0, j = 1'b0, call = 1'b0, ret = 1'b0;
    logic [3:0] bus = 4'd0;
`ifdef PC_COND_JUMP_EN
    logic       jz = 1'b0, jc = 1'b0, zf = 1'b0, cf = 1'b0;
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    logic [3:0] out_a, out_b;
    logic       emp_a, full_a, err_a, emp_b, full_b, err_b;

    // Two instances share the stimulus: a 4-deep stack and a 2-deep stack.
    program_counter_stack #(.WIDTH(4), .DEPTH(4)) dut_a (
        .clk(clk), .clr(clr), .ce(ce), .j(j), .call(call), .ret(ret), .bus(bus),
`ifdef PC_COND_JUMP_EN
        .jz(jz), .jc(jc), .zf(zf), .cf(cf),
`endif
        .out(out_a), .stack_empty(emp_a), .stack_full(full_a), .stack_err(err_a));

    program_counter_stack #(.WIDTH(4), .DEPTH(2)) dut_b (
        .clk(clk), .clr(clr), .ce(ce), .j(j), .call(call), .ret(ret), .bus(bus),
`ifdef PC_COND_JUMP_EN
        .jz(jz), .jc(jc), .zf(zf), .cf(cf),
`endif
        .out(out_b), .stack_empty(emp_b), .stack_full(full_b), .stack_err(err_b));

    typedef struct packed {
        logic [3:0] out;
        logic       emp;
        logic       full;
        logic       err;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t sb_q[$];
    int   tag_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;
    event sample_ev;

    // Reference model: plain integers, a stack array and a count per instance.
    int m_out[2];
    int m_sp[2];
    bit m_err[2];
    int m_stk[2][16];
    int m_depth[2] = '{4, 2};

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0;
            m_sp[k]  = 0;
            m_err[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(bit c_ret, bit c_call, bit c_j, bit c_ce, int b,
                                       bit c_jz, bit c_jc, bit c_zf, bit c_cf);
        for (int k = 0; k < 2; k++) begin
            if (c_ret) begin
                if (m_sp[k] == 0) m_err[k] = 1'b1;
                else begin
                    m_sp[k]  = m_sp[k] - 1;
                    m_out[k] = m_stk[k][m_sp[k]];
                end
            end else if (c_call) begin
                if (m_sp[k] == m_depth[k]) m_err[k] = 1'b1;
                else begin
                    m_stk[k][m_sp[k]] = (m_out[k] + 1) % 16;
                    m_sp[k]  = m_sp[k] + 1;
                    m_out[k] = b;
                end
            end else if (c_j) begin
                m_out[k] = b;
            end else if (COND && c_jz) begin
                if (c_zf) m_out[k] = b;
            end else if (COND && c_jc) begin
                if (c_cf) m_out[k] = b;
            end else if (c_ce) begin
                m_out[k] = (m_out[k] + 1) % 16;
            end
        end
    endfunction

    function automatic exp_t model_obs();
        exp_t e;
        e.a = {4'(m_out[0]), m_sp[0] == 0, m_sp[0] == m_depth[0], m_err[0]};
        e.b = {4'(m_out[1]), m_sp[1] == 0, m_sp[1] == m_depth[1], m_err[1]};
        return e;
    endfunction

    function automatic void sb_push();
        sb_q.push_back(model_obs());
        tag_q.push_back(step_no);
        step_no++;
    endfunction

    // One clocked command: drive at the falling edge, expect the result after the rising edge.
    task automatic cyc(input bit c_ret, input bit c_call, input bit c_j, input bit c_ce,
                       input int b, input bit c_jz = 1'b0, input bit c_jc = 1'b0,
                       input bit c_zf = 1'b0, input bit c_cf = 1'b0);
        @(negedge clk);
        ret  = c_ret;
        call = c_call;
        j    = c_j;
        ce   = c_ce;
        bus  = 4'(b);
`ifdef PC_COND_JUMP_EN
        jz = c_jz;
        jc = c_jc;
        zf = c_zf;
        cf = c_cf;
`endif
        model_step(c_ret, c_call, c_j, c_ce, b, c_jz, c_jc, c_zf, c_cf);
        sb_push();
        @(posedge clk);
    endtask

    // Called at a rising edge: raises clr between edges and expects reset values at once.
    task automatic clear_async();
        #3;
        ret = 1'b0; call = 1'b0; j = 1'b0; ce = 1'b0;
`ifdef PC_COND_JUMP_EN
        jz = 1'b0; jc = 1'b0;
`endif
        clr = 1'b1;
        model_reset();
        sb_push();
        -> sample_ev;
        @(negedge clk);
        clr = 1'b0;
        sb_push();
        @(posedge clk);
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per sample point.
    initial begin
        forever begin
            exp_t e;
            exp_t act;
            int   t;
            @(posedge clk or sample_ev);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                t   = tag_q.pop_front();
                act = {out_a, emp_a, full_a, err_a, out_b, emp_b, full_b, err_b};
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL step%0d outputs: got d4 out=%0d e/f/err=%b%b%b d2 out=%0d e/f/err=%b%b%b, expected d4 out=%0d e/f/err=%b%b%b d2 out=%0d e/f/err=%b%b%b",
                             t, act.a.out, act.a.emp, act.a.full, act.a.err,
                             act.b.out, act.b.emp, act.b.full, act.b.err,
                             e.a.out, e.a.emp, e.a.full, e.a.err,
                             e.b.out, e.b.emp, e.b.full, e.b.err);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state, then count through the wrap.
        clear_async();
        repeat (17) cyc(0, 0, 0, 1, 0);
        clear_async();

        // Jump beats increment.
        cyc(0, 0, 1, 0, 3);
        cyc(0, 0, 1, 1, 9);
        cyc(0, 0, 0, 1, 0);

        // Nested call/return.
        clear_async();
        cyc(0, 0, 1, 0, 2);
        cyc(0, 1, 0, 0, 8);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 12);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Overflow on the 2-deep stack; sticky error survives later commands.
        clear_async();
        cyc(0, 1, 0, 0, 5);
        cyc(0, 1, 0, 0, 6);
        cyc(0, 1, 0, 0, 7);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Underflow with competing commands: ret wins.
        clear_async();
        cyc(1, 0, 1, 0, 4);
        clear_async();
        cyc(1, 1, 0, 0, 9);
        // Back-to-back call/ret/call.
        clear_async();
        cyc(0, 1, 0, 0, 6);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 11);
        cyc(1, 1, 0, 0, 2);

`ifdef PC_COND_JUMP_EN
        clear_async();
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 14, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 14, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 14, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 14, 0, 1, 0, 1);
`endif

        // Randomised traffic with occasional mid-run clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                clear_async();
            end else begin
                cyc($urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 6) == 0, $urandom_range(0, 9) < 6,
                    int'($urandom_range(0, 15)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        ret = 1'b0; call = 1'b0; j = 1'b0; ce = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
